glitcbus_gclk_gen: RTL and testbench

//  Source end of the GLITCBUS clock: divides the local system clock to make GCLK (16 MHz nominal)
//  and drives it to the GLITC, whose MMCM regenerates a deskewed copy.
//  - Provides glitch-free start/stop: only whole half-periods are ever driven.
//  - Asserts ready once the far-end MMCM has had time to lock.
//  - Sits in the TISC-side GLITCBUS master; gclk_o goes to an ODDR/OBUF at top level.

---
 rtl/glitcbus_gclk_gen.sv | 112 +++++++++++
 tb/tb_glitcbus_gclk_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/glitcbus_gclk_gen.sv
// GLITCBUS GCLK source: divides clk_i by DIV into a glitch-free, 50% duty GCLK with ready after settling.
// Latency: first GCLK rise is registered on the edge that samples run_i=1; no backpressure (level request).
// Optional GCLK rise counter on cycle_cnt_o is built only when GLITCBUS_GCLK_CNT_EN is defined.
module glitcbus_gclk_gen #(
    parameter int unsigned DIV           = 8,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        run_i,
    input  logic        cnt_clear_i,
    output logic        gclk_o,
    output logic        running_o,
    output logic        ready_o,
    output logic [31:0] cycle_cnt_o
);

    localparam int unsigned DW = $clog2(DIV);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [DW-1:0] HALF_C   = DW'(DIV / 2);
    localparam logic [DW-1:0] LAST_C   = DW'(DIV - 1);
    localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_nxt;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_nxt;
    logic          active_nxt;
    logic          gclk_nxt;
    logic          rise;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = run_i ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nxt = run_i ? ST_RUN : ST_STOP;
            // STOP leaves only at a period boundary, so the last low phase is complete.
            ST_STOP: begin
                if (run_i)
                    state_nxt = ST_RUN;
                else if (div_cnt == LAST_C)
                    state_nxt = ST_IDLE;
                else
                    state_nxt = ST_STOP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // div_cnt sits at 0 in IDLE, so leaving IDLE looks exactly like a period wrap.
    always_comb begin
        active_nxt  = (state_nxt != ST_IDLE);
        div_cnt_nxt = '0;
        gclk_nxt    = 1'b0;
        if (active_nxt) begin
            div_cnt_nxt = (div_cnt == LAST_C) ? '0 : div_cnt + 1'b1;
            gclk_nxt    = (div_cnt < HALF_C);
        end
        rise = active_nxt && (div_cnt == '0);
    end

    always_comb begin
        settle_nxt = settle_cnt;
        if (state_nxt != ST_RUN)
            settle_nxt = '0;
        else if (rise && (settle_cnt < SETTLE_C))
            settle_nxt = settle_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            gclk_o     <= 1'b0;
            running_o  <= 1'b0;
            settle_cnt <= '0;
            ready_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_cnt_nxt;
            gclk_o     <= gclk_nxt;
            running_o  <= active_nxt;
            settle_cnt <= settle_nxt;
            ready_o    <= (settle_nxt == SETTLE_C);
        end
    end

`ifdef GLITCBUS_GCLK_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cycle_cnt_o <= 32'h0;
        else if (cnt_clear_i)
            cycle_cnt_o <= 32'h0;
        else if (rise)
            cycle_cnt_o <= cycle_cnt_o + 32'd1;
    end
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear_i;
    assign cycle_cnt_o      = 32'h0;
`endif

endmodule

// File: tb/tb_glitcbus_gclk_gen.sv
// Randomized and directed bench for glitcbus_gclk_gen (DIV=8, SETTLE_CYCLES=4) against an output-phase model.
module tb_glitcbus_gclk_gen;

    localparam int DIV    = 8;
    localparam int HALF   = DIV / 2;
    localparam int SETTLE = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        run_i;
    logic        cnt_clear_i;
    logic        gclk_o;
    logic        running_o;
    logic        ready_o;
    logic [31:0] cycle_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase of the emitted clock within its period, not the divider state.
    bit          m_active;
    int          m_ph;
    bit          m_prev_run;
    int          m_settle;
    bit          m_gclk;
    bit          m_ready;
    logic [31:0] m_cnt;
    bit          m_rise;

    glitcbus_gclk_gen #(
        .DIV          (DIV),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .run_i      (run_i),
        .cnt_clear_i(cnt_clear_i),
        .gclk_o     (gclk_o),
        .running_o  (running_o),
        .ready_o    (ready_o),
        .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_ph       = 0;
        m_prev_run = 1'b0;
        m_settle   = 0;
        m_gclk     = 1'b0;
        m_ready    = 1'b0;
        m_cnt      = 32'h0;
        m_rise     = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit c);
        m_rise = 1'b0;
        if (!m_active) begin
            if (r) begin
                m_active = 1'b1;
                m_ph     = 0;
                m_rise   = 1'b1;
            end
        end else if (!r && !m_prev_run && m_ph == DIV - 2) begin
            // stop request held: the clock ends after its final low phase
            m_active = 1'b0;
        end else begin
            m_ph   = (m_ph + 1) % DIV;
            m_rise = (m_ph == 0);
        end
        m_prev_run = r;
        if (r) begin
            if (m_rise) m_settle++;
        end else begin
            m_settle = 0;
        end
        m_ready = r && (m_settle >= SETTLE);
        m_gclk  = m_active && (m_ph < HALF);
`ifdef GLITCBUS_GCLK_CNT_EN
        if (c)
            m_cnt = 32'h0;
        else if (m_rise)
            m_cnt = m_cnt + 32'd1;
`else
        if (c) m_cnt = 32'h0;
`endif
    endtask

    task automatic check_all();
        chk_val("gclk",    {31'b0, gclk_o},    {31'b0, m_gclk});
        chk_val("running", {31'b0, running_o}, {31'b0, m_active});
        chk_val("ready",   {31'b0, ready_o},   {31'b0, m_ready});
        chk_val("cnt",     cycle_cnt_o,        m_cnt);
    endtask

    task automatic tick(input bit r, input bit c);
        run_i       = r;
        cnt_clear_i = c;
        @(posedge clk_i);
        model_edge(r, c);
        @(negedge clk_i);
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk_val({tag, "_gclk"},    {31'b0, gclk_o},    32'h0);
        chk_val({tag, "_running"}, {31'b0, running_o}, 32'h0);
        chk_val({tag, "_ready"},   {31'b0, ready_o},   32'h0);
        chk_val({tag, "_cnt"},     cycle_cnt_o,        32'h0);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst_n_i     = 1'b0;
        run_i       = 1'b0;
        cnt_clear_i = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        int high_len;
        int guard;
        bit r;
        model_reset();
        rst_n_i     = 1'b0;
        run_i       = 1'b0;
        cnt_clear_i = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Start-up: idle, then run; first rise one cycle after run sampled
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk_val("first_rise", {31'b0, gclk_o}, 32'h1);
        high_len = 1;
        for (int i = 0; i < 39; i++) begin
            tick(1'b1, 1'b0);
            if (i < 7 && gclk_o) high_len++;
        end
        chk_val("high_len", high_len, HALF);
        chk_val("ready_held", {31'b0, ready_o}, 32'h1);

        // Stop on the second cycle of a high phase
        guard = 0;
        while (!(m_active && m_ph == 1) && guard < 4 * DIV) begin
            tick(1'b1, 1'b0);
            guard++;
        end
        chk_val("align_stop", {31'b0, (guard < 4 * DIV)}, 32'h1);
        for (int i = 0; i < 3 * DIV; i++) tick(1'b0, 1'b0);
        chk_val("stopped_running", {31'b0, running_o}, 32'h0);
        chk_val("stopped_gclk", {31'b0, gclk_o}, 32'h0);

        // Brief drop mid-period, then resume
        for (int i = 0; i < 6 * DIV + 2; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 6 * DIV; i++) tick(1'b1, 1'b0);

        // Asynchronous reset while GCLK is high, then a clean restart
        guard = 0;
        while (!gclk_o && guard < 2 * DIV) begin
            tick(1'b1, 1'b0);
            guard++;
        end
        chk_val("align_rst", {31'b0, gclk_o}, 32'h1);
        pulse_reset("midrst");
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk_val("restart_rise", {31'b0, gclk_o}, 32'h1);

        // Ten rises from a fresh reset, then clear on a rising-edge cycle
        pulse_reset("cntrst");
        for (int i = 0; i < 1 + 9 * DIV; i++) tick(1'b1, 1'b0);
`ifdef GLITCBUS_GCLK_CNT_EN
        chk_val("cnt_ten", cycle_cnt_o, 32'd10);
`else
        chk_val("cnt_ten", cycle_cnt_o, 32'd0);
`endif
        guard = 0;
        while (m_ph != DIV - 1 && guard < 2 * DIV) begin
            tick(1'b1, 1'b0);
            guard++;
        end
        tick(1'b1, 1'b1);
        chk_val("clear_on_rise", cycle_cnt_o, 32'd0);
        chk_val("clear_rise_seen", {31'b0, gclk_o}, 32'h1);

        // Random run_i: held levels and per-cycle toggling, sparse clears
        for (int blk = 0; blk < 250; blk++) begin
            int len;
            len = $urandom_range(1, 20);
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < len; i++) tick(i[0], ($urandom_range(0, 31) == 0));
            end else begin
                r = $urandom_range(0, 2) != 0;
                for (int i = 0; i < len; i++) tick(r, ($urandom_range(0, 31) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
